econ_4x4_d10_core: RTL and testbench
====================================

Name: econ_4x4_d10_core

Overview:
Fixed-point inference core for the ECON 4x4 encoder.
- Datapath: 4x4x3 input image -> 3x3 same-padding Conv2D (8 filters) -> ReLU -> flatten (128) -> Dense (10 outputs).
- Weights and biases are loaded through ports together with each image.
- Computes serially and produces one valid output word per accepted input.

Parameters:
- IN_W, 22: width of each signed input element and each signed output element.
- WT_W, 8: width of each signed weight and bias.
- ACT_W, 16: width of each unsigned ReLU activation.
- SHIFT2, 8: conv requantisation right-shift.
- SHIFT4, 8: dense requantisation right-shift.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- input_1_rsc_dat  in  1056  48 elements; element i=(r*4+c)*3+ch at bits [22i+21:22i]
- input_1_rsc_vld  in  1  image valid
- input_1_rsc_triosy_lz  out  1  capture pulse
- w2_rsc_dat  in  1728  216 weights; index ((kr*3+kc)*3+ci)*8+co, 8 bits each
- w2_rsc_vld / w2_rsc_triosy_lz  in/out  1  valid / capture pulse
- b2_rsc_dat  in  64  8 biases, co at [8co+7:8co]
- b2_rsc_vld / b2_rsc_triosy_lz  in/out  1
- w4_rsc_dat  in  10240  1280 weights; index j*10+o, j=(r*4+c)*8+co
- w4_rsc_vld / w4_rsc_triosy_lz  in/out  1
- b4_rsc_dat  in  80  10 biases, o at [8o+7:8o]
- b4_rsc_vld / b4_rsc_triosy_lz  in/out  1
- layer5_out_rsc_dat  out  220  10 signed outputs, o at [22o+21:22o]
- layer5_out_rsc_vld / layer5_out_rsc_triosy_lz  out  1  result valid pulse / companion pulse
- const_size_in_1_rsc_dat  out  16  constant 48
- const_size_in_1_rsc_vld / _triosy_lz  out  1
- const_size_out_1_rsc_dat  out  16  constant 10
- const_size_out_1_rsc_vld / _triosy_lz  out  1

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: state IDLE; all vld and triosy outputs 0; layer5_out_rsc_dat = 0. Const dat outputs hold their constant values always.
- IDLE: when input_1_rsc_vld and all four weight/bias vlds are 1 in the same cycle (cycle 0):
  - Register all inputs.
  - Pulse every input-side triosy for 1 cycle.
  - Go to CONV.
  - If any vld is 0, wait. There are no ready signals.
- CONV, cycles 1..128: one activation per cycle, order (r, c, co).
  - acc = sum over the 3x3x3 window of x*w2, plus (b2 << SHIFT2). Out-of-image taps contribute 0.
  - act = clamp(acc >>> SHIFT2, 0, 2^ACT_W-1). The shift is arithmetic (floor); clamp applies ReLU and saturation.
- DENSE, cycles 129..138: one output per cycle.
  - acc = sum_j act[j]*w4[j*10+o], plus (b4 << SHIFT4).
  - out = saturate signed IN_W (acc >>> SHIFT4).
- DONE, cycle 139:
  - layer5_out_rsc_vld = 1 with data held.
  - layer5_out, const_size_in_1 and const_size_out_1 triosy and vld pulse for exactly that cycle.
  - Next state IDLE.
  - Data holds until the next DONE.
- Accumulators are at least 35 bits (conv) and 33 bits (dense); no internal overflow.
- Input vlds are ignored outside IDLE.
- If vlds are held high, a new capture occurs on the cycle after DONE, giving a period of 140 cycles.
- reset asserted mid-operation aborts the computation and returns to reset values the following cycle.

Optional Feature:
- Macro ROUNDING_EN.
- When defined, both requantisations add 2^(SHIFT-1) before the shift (round half up), then saturate.
- When undefined, floor truncation.

Decomposition:
- Package econ_pkg:
  - Width parameters and element counts (48, 216, 8, 1280, 10, 128).
  - Signed/unsigned element typedefs.
  - Index helper functions.
  - Saturate/requantise function (honours ROUNDING_EN).
- One sub-module, econ_mac_tree: parameterised signed multiply-accumulate sum of N products, instantiated for N=27 (conv) and N=128 (dense).

Test Plan:
- Bias path: all x and weights 0, b2=0, b4[o]=o -> out[o]=o.
  - vld pulses exactly 139 cycles after capture, 1 cycle wide.
  - const dat = 48 and 10.
- Single tap: x=256 everywhere; w2 centre tap ci0->co0 = 1, rest 0; b=0; w4 all 127.
  - act co0 = 1 at all 16 pixels.
  - out[o] = 7, or 8 with ROUNDING_EN.
- ReLU: as the single-tap case but x=0, b2[co0]=-1, b4=5 -> out[o]=5 (negative activation clamped to 0).
- Saturation:
  - x = 2097151, w2 all 127, w4 all 127 -> all outputs 2097151.
  - w4 all -128 -> all outputs -2097152.
- Reset mid-computation at cycle 60 -> no vld pulse for the aborted image.
  - Next capture after reset deassertion yields the correct result at capture+139.
- vlds held high continuously -> output vld pulses every 140 cycles with identical data.
  - One input vld low at the IDLE cycle -> no capture until it rises.

Source files
------------

// File: rtl/econ_pkg.sv
// Shared widths, element counts, index helpers and requantisation for the ECON 4x4 core.
// Define ROUNDING_EN for round-half-up requantisation; the default is floor truncation.
package econ_pkg;
  localparam int IN_W   = 22;
  localparam int WT_W   = 8;
  localparam int ACT_W  = 16;
  localparam int SHIFT2 = 8;
  localparam int SHIFT4 = 8;

  localparam int N_IN  = 48;
  localparam int N_W2  = 216;
  localparam int N_B2  = 8;
  localparam int N_W4  = 1280;
  localparam int N_B4  = 10;
  localparam int N_ACT = 128;
  localparam int N_TAP = 27;
  localparam int N_CH  = 3;
  localparam int DIM   = 4;
  localparam int ACC_W = 40;

  typedef logic signed [IN_W-1:0]  elem_t;
  typedef logic signed [WT_W-1:0]  wt_t;
  typedef logic        [ACT_W-1:0] act_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DENSE, S_DONE} state_t;

  localparam acc_t ACC_ZERO = '0;
  localparam acc_t ACT_MAX  = acc_t'((1 << ACT_W) - 1);
  localparam acc_t OUT_MAX  = acc_t'((1 << (IN_W - 1)) - 1);
  localparam acc_t OUT_MIN  = acc_t'(-(1 << (IN_W - 1)));

  function automatic int x_idx(input int r, input int c, input int ch);
    return (r * DIM + c) * N_CH + ch;
  endfunction

  function automatic int w2_idx(input int kr, input int kc, input int ci, input int co);
    return ((kr * 3 + kc) * N_CH + ci) * N_B2 + co;
  endfunction

  function automatic int w4_idx(input int j, input int o);
    return j * N_B4 + o;
  endfunction

  // Bias is pre-scaled so it lines up with the product fixed point.
  function automatic acc_t bias_acc(input wt_t b, input int sh);
    return acc_t'(b) <<< sh;
  endfunction

  function automatic acc_t requant(input acc_t acc, input int sh);
    acc_t t;
    t = acc;
`ifdef ROUNDING_EN
    t = t + (acc_t'(1) <<< (sh - 1));
`endif
    return t >>> sh;
  endfunction

  // ReLU and saturation fold into a single clamp.
  function automatic act_t sat_act(input acc_t v);
    if (v < ACC_ZERO) return '0;
    if (v > ACT_MAX)  return '1;
    return v[ACT_W-1:0];
  endfunction

  function automatic elem_t sat_out(input acc_t v);
    if (v > OUT_MAX) return elem_t'(OUT_MAX);
    if (v < OUT_MIN) return elem_t'(OUT_MIN);
    return v[IN_W-1:0];
  endfunction
endpackage

// File: rtl/econ_mac_tree.sv
// Combinational signed sum of N products a[i]*b[i], each sign-extended before accumulation.
module econ_mac_tree #(
  parameter int N     = 27,
  parameter int A_W   = 22,
  parameter int B_W   = 8,
  parameter int ACC_W = 40
) (
  input  logic [N-1:0][A_W-1:0]  a,
  input  logic [N-1:0][B_W-1:0]  b,
  output logic signed [ACC_W-1:0] sum
);
  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] prod [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign prod[i] = P_W'($signed(a[i])) * P_W'($signed(b[i]));
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + ACC_W'(prod[i]);
  end
endmodule

// File: rtl/econ_4x4_d10_core.sv
// ECON 4x4 encoder core: serial 3x3 conv (8 filters) + ReLU, then 128->10 dense.
// Define ROUNDING_EN for round-half-up requantisation in both layers.
module econ_4x4_d10_core
  import econ_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IN_W*N_IN-1:0]   input_1_rsc_dat,
  input  logic                   input_1_rsc_vld,
  output logic                   input_1_rsc_triosy_lz,
  input  logic [WT_W*N_W2-1:0]   w2_rsc_dat,
  input  logic                   w2_rsc_vld,
  output logic                   w2_rsc_triosy_lz,
  input  logic [WT_W*N_B2-1:0]   b2_rsc_dat,
  input  logic                   b2_rsc_vld,
  output logic                   b2_rsc_triosy_lz,
  input  logic [WT_W*N_W4-1:0]   w4_rsc_dat,
  input  logic                   w4_rsc_vld,
  output logic                   w4_rsc_triosy_lz,
  input  logic [WT_W*N_B4-1:0]   b4_rsc_dat,
  input  logic                   b4_rsc_vld,
  output logic                   b4_rsc_triosy_lz,
  output logic [IN_W*N_B4-1:0]   layer5_out_rsc_dat,
  output logic                   layer5_out_rsc_vld,
  output logic                   layer5_out_rsc_triosy_lz,
  output logic [15:0]            const_size_in_1_rsc_dat,
  output logic                   const_size_in_1_rsc_vld,
  output logic                   const_size_in_1_rsc_triosy_lz,
  output logic [15:0]            const_size_out_1_rsc_dat,
  output logic                   const_size_out_1_rsc_vld,
  output logic                   const_size_out_1_rsc_triosy_lz
);
  localparam logic [6:0] CONV_LAST  = 7'(N_ACT - 1);
  localparam logic [6:0] DENSE_LAST = 7'(N_B4 - 1);

  state_t state;
  logic [6:0] cnt;
  logic cap_pulse, done_pulse;

  logic [IN_W*N_IN-1:0] x_q;
  logic [WT_W*N_W2-1:0] w2_q;
  logic [WT_W*N_B2-1:0] b2_q;
  logic [WT_W*N_W4-1:0] w4_q;
  logic [WT_W*N_B4-1:0] b4_q;
  logic [N_ACT-1:0][ACT_W-1:0] act_q;
  logic [N_B4-1:0][IN_W-1:0]   res_q, res_nxt;

  logic all_vld;
  assign all_vld = &{input_1_rsc_vld, w2_rsc_vld, b2_rsc_vld, w4_rsc_vld, b4_rsc_vld};

  // Conv counter walks (r, c, co) with co fastest.
  logic [1:0] pr, pc;
  logic [2:0] pco;
  logic [3:0] o_sel;
  assign pr    = cnt[6:5];
  assign pc    = cnt[4:3];
  assign pco   = cnt[2:0];
  assign o_sel = (cnt < 7'(N_B4)) ? cnt[3:0] : 4'd0;

  logic [N_TAP-1:0][IN_W-1:0] c_a;
  logic [N_TAP-1:0][WT_W-1:0] c_b;
  logic [N_ACT-1:0][ACT_W:0]  d_a;
  logic [N_ACT-1:0][WT_W-1:0] d_b;

  always_comb begin
    c_a = '0;
    c_b = '0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        for (int ci = 0; ci < N_CH; ci++) begin
          c_b[(kr*3+kc)*N_CH+ci] = w2_q[w2_idx(kr, kc, ci, int'(pco))*WT_W +: WT_W];
          // Taps falling outside the 4x4 image stay zero (same padding).
          if (int'(pr) + kr >= 1 && int'(pr) + kr <= DIM &&
              int'(pc) + kc >= 1 && int'(pc) + kc <= DIM)
            c_a[(kr*3+kc)*N_CH+ci] =
              x_q[x_idx(int'(pr)+kr-1, int'(pc)+kc-1, ci)*IN_W +: IN_W];
        end
  end

  always_comb begin
    for (int j = 0; j < N_ACT; j++) begin
      d_a[j] = {1'b0, act_q[j]};
      d_b[j] = w4_q[w4_idx(j, int'(o_sel))*WT_W +: WT_W];
    end
  end

  acc_t c_sum, d_sum, conv_acc, dense_acc;
  act_t act_nxt;
  elem_t dense_out;

  econ_mac_tree #(.N(N_TAP), .A_W(IN_W), .B_W(WT_W), .ACC_W(ACC_W)) u_conv_mac (
    .a(c_a), .b(c_b), .sum(c_sum)
  );

  econ_mac_tree #(.N(N_ACT), .A_W(ACT_W+1), .B_W(WT_W), .ACC_W(ACC_W)) u_dense_mac (
    .a(d_a), .b(d_b), .sum(d_sum)
  );

  assign conv_acc  = c_sum + bias_acc(b2_q[int'(pco)*WT_W +: WT_W], SHIFT2);
  assign dense_acc = d_sum + bias_acc(b4_q[int'(o_sel)*WT_W +: WT_W], SHIFT4);
  assign act_nxt   = sat_act(requant(conv_acc, SHIFT2));
  assign dense_out = sat_out(requant(dense_acc, SHIFT4));

  always_comb begin
    res_nxt        = res_q;
    res_nxt[o_sel] = dense_out;
  end

  // Datapath storage needs no reset; the FSM gates every write.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && all_vld) begin
      x_q  <= input_1_rsc_dat;
      w2_q <= w2_rsc_dat;
      b2_q <= b2_rsc_dat;
      w4_q <= w4_rsc_dat;
      b4_q <= b4_rsc_dat;
    end
    if (state == S_CONV)  act_q[cnt]   <= act_nxt;
    if (state == S_DENSE) res_q[o_sel] <= dense_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      cnt                <= '0;
      cap_pulse          <= 1'b0;
      done_pulse         <= 1'b0;
      layer5_out_rsc_dat <= '0;
    end else begin
      cap_pulse  <= 1'b0;
      done_pulse <= 1'b0;
      case (state)
        S_IDLE: if (all_vld) begin
          cap_pulse <= 1'b1;
          cnt       <= '0;
          state     <= S_CONV;
        end
        S_CONV: begin
          cnt <= cnt + 7'd1;
          if (cnt == CONV_LAST) begin
            cnt   <= '0;
            state <= S_DENSE;
          end
        end
        S_DENSE: begin
          cnt <= cnt + 7'd1;
          if (cnt == DENSE_LAST) begin
            cnt                <= '0;
            layer5_out_rsc_dat <= res_nxt;
            done_pulse         <= 1'b1;
            state              <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign input_1_rsc_triosy_lz = cap_pulse;
  assign w2_rsc_triosy_lz      = cap_pulse;
  assign b2_rsc_triosy_lz      = cap_pulse;
  assign w4_rsc_triosy_lz      = cap_pulse;
  assign b4_rsc_triosy_lz      = cap_pulse;

  assign layer5_out_rsc_vld             = done_pulse;
  assign layer5_out_rsc_triosy_lz       = done_pulse;
  assign const_size_in_1_rsc_vld        = done_pulse;
  assign const_size_in_1_rsc_triosy_lz  = done_pulse;
  assign const_size_out_1_rsc_vld       = done_pulse;
  assign const_size_out_1_rsc_triosy_lz = done_pulse;

  assign const_size_in_1_rsc_dat  = 16'(N_IN);
  assign const_size_out_1_rsc_dat = 16'(N_B4);
endmodule

// File: tb/tb_econ_4x4_d10_core.sv
// Scoreboard bench for econ_4x4_d10_core: directed corner images plus random images vs a plain-arithmetic model.
module tb_econ_4x4_d10_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1055:0]  input_1_rsc_dat;
  logic           input_1_rsc_vld, input_1_rsc_triosy_lz;
  logic [1727:0]  w2_rsc_dat;
  logic           w2_rsc_vld, w2_rsc_triosy_lz;
  logic [63:0]    b2_rsc_dat;
  logic           b2_rsc_vld, b2_rsc_triosy_lz;
  logic [10239:0] w4_rsc_dat;
  logic           w4_rsc_vld, w4_rsc_triosy_lz;
  logic [79:0]    b4_rsc_dat;
  logic           b4_rsc_vld, b4_rsc_triosy_lz;
  logic [219:0]   layer5_out_rsc_dat;
  logic           layer5_out_rsc_vld, layer5_out_rsc_triosy_lz;
  logic [15:0]    const_size_in_1_rsc_dat, const_size_out_1_rsc_dat;
  logic           const_size_in_1_rsc_vld, const_size_in_1_rsc_triosy_lz;
  logic           const_size_out_1_rsc_vld, const_size_out_1_rsc_triosy_lz;

  econ_4x4_d10_core dut (
    .clk(clk), .reset(reset),
    .input_1_rsc_dat(input_1_rsc_dat), .input_1_rsc_vld(input_1_rsc_vld),
    .input_1_rsc_triosy_lz(input_1_rsc_triosy_lz),
    .w2_rsc_dat(w2_rsc_dat), .w2_rsc_vld(w2_rsc_vld), .w2_rsc_triosy_lz(w2_rsc_triosy_lz),
    .b2_rsc_dat(b2_rsc_dat), .b2_rsc_vld(b2_rsc_vld), .b2_rsc_triosy_lz(b2_rsc_triosy_lz),
    .w4_rsc_dat(w4_rsc_dat), .w4_rsc_vld(w4_rsc_vld), .w4_rsc_triosy_lz(w4_rsc_triosy_lz),
    .b4_rsc_dat(b4_rsc_dat), .b4_rsc_vld(b4_rsc_vld), .b4_rsc_triosy_lz(b4_rsc_triosy_lz),
    .layer5_out_rsc_dat(layer5_out_rsc_dat), .layer5_out_rsc_vld(layer5_out_rsc_vld),
    .layer5_out_rsc_triosy_lz(layer5_out_rsc_triosy_lz),
    .const_size_in_1_rsc_dat(const_size_in_1_rsc_dat),
    .const_size_in_1_rsc_vld(const_size_in_1_rsc_vld),
    .const_size_in_1_rsc_triosy_lz(const_size_in_1_rsc_triosy_lz),
    .const_size_out_1_rsc_dat(const_size_out_1_rsc_dat),
    .const_size_out_1_rsc_vld(const_size_out_1_rsc_vld),
    .const_size_out_1_rsc_triosy_lz(const_size_out_1_rsc_triosy_lz)
  );

  int x [48];
  int w2 [216];
  int b2 [8];
  int w4 [1280];
  int b4 [10];

  typedef struct { logic [219:0] dat; int t; } exp_t;
  exp_t sb [$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [219:0] got, input logic [219:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Requantise: divide by 256 rounding toward -inf (optionally half-up first).
  function automatic longint rq(input longint a);
    longint v, q;
    v = a;
`ifdef ROUNDING_EN
    v = v + 128;
`endif
    q = v / 256;
    if (v % 256 != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [219:0] model();
    longint act [128];
    longint acc;
    int rr, cc;
    logic [219:0] r;
    r = '0;
    for (int p = 0; p < 16; p++)
      for (int co = 0; co < 8; co++) begin
        acc = longint'(b2[co]) * 256;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++) begin
            rr = p / 4 + kr - 1;
            cc = p % 4 + kc - 1;
            if (rr >= 0 && rr < 4 && cc >= 0 && cc < 4)
              for (int ci = 0; ci < 3; ci++)
                acc += longint'(x[(rr*4+cc)*3+ci]) * longint'(w2[((kr*3+kc)*3+ci)*8+co]);
          end
        act[p*8+co] = clampl(rq(acc), 0, 65535);
      end
    for (int o = 0; o < 10; o++) begin
      acc = longint'(b4[o]) * 256;
      for (int j = 0; j < 128; j++) acc += act[j] * longint'(w4[j*10+o]);
      r[o*22 +: 22] = 22'(clampl(rq(acc), -2097152, 2097151));
    end
    return r;
  endfunction

  task automatic clear_img();
    foreach (x[i])  x[i]  = 0;
    foreach (w2[i]) w2[i] = 0;
    foreach (b2[i]) b2[i] = 0;
    foreach (w4[i]) w4[i] = 0;
    foreach (b4[i]) b4[i] = 0;
  endtask

  task automatic rand_img();
    int m;
    m = int'($urandom_range(4, 12));
    foreach (x[i])  x[i]  = int'($urandom_range(0, (1 << m) - 1)) - (1 << (m - 1));
    foreach (w2[i]) w2[i] = int'($urandom_range(0, 255)) - 128;
    foreach (b2[i]) b2[i] = int'($urandom_range(0, 255)) - 128;
    foreach (w4[i]) w4[i] = int'($urandom_range(0, 255)) - 128;
    foreach (b4[i]) b4[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic load();
    foreach (x[i])  input_1_rsc_dat[i*22 +: 22] = 22'(x[i]);
    foreach (w2[i]) w2_rsc_dat[i*8 +: 8] = 8'(w2[i]);
    foreach (b2[i]) b2_rsc_dat[i*8 +: 8] = 8'(b2[i]);
    foreach (w4[i]) w4_rsc_dat[i*8 +: 8] = 8'(w4[i]);
    foreach (b4[i]) b4_rsc_dat[i*8 +: 8] = 8'(b4[i]);
  endtask

  task automatic set_vld(input logic v);
    input_1_rsc_vld = v; w2_rsc_vld = v; b2_rsc_vld = v; w4_rsc_vld = v; b4_rsc_vld = v;
  endtask

  function automatic logic [219:0] in_trio();
    return 220'({input_1_rsc_triosy_lz, w2_rsc_triosy_lz, b2_rsc_triosy_lz,
                 w4_rsc_triosy_lz, b4_rsc_triosy_lz});
  endfunction

  // Called at a negedge while the DUT is idle; the result is due 139 cycles on.
  task automatic issue(input bit expect_out);
    exp_t e;
    load();
    set_vld(1'b1);
    if (expect_out) begin
      e.dat = model();
      e.t   = cyc + 139;
      sb.push_back(e);
    end
    @(negedge clk);
    check("capture_triosy", in_trio(), 220'h1f);
    set_vld(1'b0);
    @(negedge clk);
    check("capture_triosy_end", in_trio(), 220'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", 220'(sb.size()), 220'h0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      check("done_pulses",
            220'({layer5_out_rsc_triosy_lz, const_size_in_1_rsc_vld, const_size_in_1_rsc_triosy_lz,
                  const_size_out_1_rsc_vld, const_size_out_1_rsc_triosy_lz}),
            220'({5{layer5_out_rsc_vld}}));
      if (layer5_out_rsc_vld) begin
        if (sb.size() == 0) check("unexpected_vld", 220'h1, 220'h0);
        else begin
          e = sb.pop_front();
          check("out_dat", layer5_out_rsc_dat, e.dat);
          check("out_time", 220'(cyc), 220'(e.t));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [219:0] d;
    input_1_rsc_dat = '0; w2_rsc_dat = '0; b2_rsc_dat = '0; w4_rsc_dat = '0; b4_rsc_dat = '0;
    set_vld(1'b0);
    clear_img();
    repeat (3) @(negedge clk);
    check("reset_vld", 220'(layer5_out_rsc_vld), 220'h0);
    check("reset_dat", layer5_out_rsc_dat, 220'h0);
    check("reset_in_triosy", in_trio(), 220'h0);
    check("const_in_dat", 220'(const_size_in_1_rsc_dat), 220'd48);
    check("const_out_dat", 220'(const_size_out_1_rsc_dat), 220'd10);
    reset = 1'b0;
    @(negedge clk);

    // Bias only: out[o] = o
    clear_img();
    foreach (b4[o]) b4[o] = o;
    issue(1'b1);
    wait_idle();

    // Single centre tap ci0->co0, x=256
    clear_img();
    foreach (x[i]) x[i] = 256;
    w2[((1*3+1)*3+0)*8+0] = 1;
    foreach (w4[i]) w4[i] = 127;
    issue(1'b1);
    wait_idle();

    // Negative conv result is clamped by ReLU
    foreach (x[i]) x[i] = 0;
    b2[0] = -1;
    foreach (b4[o]) b4[o] = 5;
    issue(1'b1);
    wait_idle();

    // Positive and negative saturation
    clear_img();
    foreach (x[i])  x[i]  = 2097151;
    foreach (w2[i]) w2[i] = 127;
    foreach (w4[i]) w4[i] = 127;
    issue(1'b1);
    wait_idle();
    foreach (w4[i]) w4[i] = -128;
    issue(1'b1);
    wait_idle();

    for (int k = 0; k < 8; k++) begin
      rand_img();
      issue(1'b1);
      wait_idle();
    end

    // Abort at cycle 60: no result for this image, next one must be clean
    rand_img();
    issue(1'b0);
    repeat (58) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_vld", 220'(layer5_out_rsc_vld), 220'h0);
    check("abort_dat", layer5_out_rsc_dat, 220'h0);
    reset = 1'b0;
    rand_img();
    issue(1'b1);
    wait_idle();

    // vlds held high: three back-to-back runs, 140 cycles apart
    rand_img();
    load();
    d = model();
    set_vld(1'b1);
    for (int k = 0; k < 3; k++) begin
      e.dat = d;
      e.t   = cyc + 139 + 140 * k;
      sb.push_back(e);
    end
    repeat (281) @(negedge clk);
    set_vld(1'b0);
    wait_idle();

    // One vld low blocks capture until it rises
    rand_img();
    load();
    set_vld(1'b1);
    w4_rsc_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_capture", in_trio(), 220'h0);
    end
    w4_rsc_vld = 1'b1;
    e.dat = model();
    e.t   = cyc + 139;
    sb.push_back(e);
    @(negedge clk);
    check("late_capture_triosy", in_trio(), 220'h1f);
    set_vld(1'b0);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
